serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial N-bit adder: the additive counterpart of the team's combinational full subtractor. It reuses one full-adder cell and one carry flip-flop, and processes operands LSB first, one bit per clock. A start/busy/done handshake frames each operation, and the result is held stable between operations. It targets area-constrained datapaths where a WIDTH-cycle latency is acceptable.

## Interface
- WIDTH, 8: operand and result width in bits; legal range ≥ 2.
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request a new addition; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- clr  input  1  synchronous abort; highest priority below reset.
- busy  output  1  high while the adder is in RUN.
- done  output  1  one-cycle pulse; sum, cout and ovf are valid from this cycle on.
- sum  output  WIDTH  registered result of a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.

## Operation
- State machine has three states: IDLE, RUN, DONE.
  - IDLE: if start=1, load a and b into shift registers sa and sb, load the carry FF with cin, clear the bit counter, and go to RUN.
  - RUN: each cycle, compute s = sa[0]^sb[0]^c and c' = sa[0]&sb[0] | c&(sa[0]^sb[0]).
  - RUN: shift s into the MSB of accumulator acc, shift sa and sb right by 1, set c ← c', and increment the counter.
  - RUN: on the edge that processes bit WIDTH-1, load sum ← final acc, cout ← c', and ovf ← c XOR c' (c is the carry into the MSB). Then go to DONE.
  - DONE: done=1 for exactly this cycle. If start=1, accept the new operands exactly as IDLE does and go to RUN. Otherwise go to IDLE.
- start while in RUN is ignored; no queuing.
- clr=1 in any state forces IDLE on the next edge and deasserts busy and done. It leaves sum, cout and ovf unchanged and discards the operation in progress.
- sum, cout and ovf change only on the edge that enters DONE. They hold their value through IDLE and the next RUN.
- The counter is $clog2(WIDTH)+1 bits wide so that it cannot wrap within an operation.
- Arithmetic is unsigned modulo 2^WIDTH.
  - cout is the unsigned carry.
  - ovf is valid for two's-complement interpretation.
  - cin participates exactly as a bit-0 carry.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - state = IDLE;
  - busy, done, sum, cout and ovf all 0;
  - shift registers, counter and carry FF all 0.
- Release of reset is synchronous to clk. The first start is sampled on the first rising edge with rst_n=1.
- Latency: start accepted on edge E0 → busy=1 from E0 through the cycle before E(WIDTH).
- On edge E(WIDTH): state becomes DONE, busy=0, done=1, and the result is valid.
- done falls on E(WIDTH+1).
- Throughput: with start held high, one result every WIDTH+1 cycles, because DONE→RUN has no IDLE bubble.
- Operands only need to be valid on the accepting edge; a and b may change freely while busy.
- Reset asserted during RUN aborts immediately. Outputs go to 0 without waiting for a clock edge.
- clr and start high on the same edge: clr wins and the state goes to IDLE.

## Test plan
- WIDTH=8, a=8'hFF, b=8'h01, cin=0 → after 8 RUN cycles done pulses with sum=8'h00, cout=1, ovf=0. busy is high for exactly 8 cycles.
- a=8'h7F, b=8'h01, cin=0 → sum=8'h80, cout=0, ovf=1. Then a=8'h80, b=8'h80 → sum=8'h00, cout=1, ovf=1.
- a=8'h3C, b=8'hA5, cin=1 → sum=8'hE2, cout=0, ovf=0. sum holds its previous value during the whole RUN and updates only when done=1.
- Hold start high across two operations (8'h01+8'h02, then 8'h10+8'h20) → done pulses 9 cycles apart with sums 8'h03 and 8'h30. A start pulse mid-RUN with different operands is ignored and does not change the result.
- Pull rst_n low 3 cycles into RUN → busy, done, sum, cout and ovf are 0 immediately without waiting for clk. A subsequent 8'h05+8'h06 gives 8'h0B.
- Assert clr 4 cycles into RUN → IDLE on the next edge with no done pulse, and the previous sum is retained. Exhaustive sweep with WIDTH=4 over all a, b and cin → every result matches a+b+cin.

Source files
------------

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, LSB first, one full-adder cell and one carry FF
// start/busy/done framing; sum/cout/ovf are registered and only update when entering DONE.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             clr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-2:0] acc_q;
    logic             c_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic             bit_s;
    logic             c_d;
    logic [WIDTH-1:0] acc_d;
    logic             last_bit;

    // The shared full-adder cell; acc_d is the accumulator after shifting in this cycle's bit.
    always_comb begin
        bit_s    = sa_q[0] ^ sb_q[0] ^ c_q;
        c_d      = (sa_q[0] & sb_q[0]) | (c_q & (sa_q[0] ^ sb_q[0]));
        acc_d    = {bit_s, acc_q};
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (clr) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        c_q     <= cin;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    sa_q  <= {1'b0, sa_q[WIDTH-1:1]};
                    sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
                    acc_q <= acc_d[WIDTH-1:1];
                    c_q   <= c_d;
                    if (last_bit) begin
                        sum_q   <= acc_d;
                        cout_q  <= c_d;
                        ovf_q   <= c_q ^ c_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized and directed self-checking bench for serial_adder
// An 8-bit instance carries the directed/random tests; a 4-bit instance is swept exhaustively.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0, cin8 = 1'b0, clr8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    logic       start4 = 1'b0, cin4 = 1'b0, clr4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] sum4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8), .clr(clr8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4), .clr(clr4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for sum/cout, signed range test for ovf.
    task automatic model(input int w, input int x, input int y, input int c,
                         output int s, output int co, output int ov);
        int total, sx, sy, st, half;
        half  = 1 << (w - 1);
        total = x + y + c;
        s     = total % (1 << w);
        co    = total / (1 << w);
        sx    = (x >= half) ? x - (1 << w) : x;
        sy    = (y >= half) ? y - (1 << w) : y;
        st    = sx + sy + c;
        ov    = (st >= half || st < -half) ? 1 : 0;
    endtask

    task automatic run8(input string tag, input logic [7:0] x, input logic [7:0] y, input logic c,
                        input bit noisy);
        int es, eco, eov, n, nbusy;
        logic [7:0] prev;
        bit held;
        model(8, int'(x), int'(y), int'(c), es, eco, eov);
        @(negedge clk);
        prev = sum8;
        a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        n = 0; nbusy = 0; held = 1'b1;
        while (done8 !== 1'b1 && n < 40) begin
            if (busy8 === 1'b1) nbusy++;
            if (sum8 !== prev) held = 1'b0;
            if (noisy) begin
                start8 = 1'($urandom_range(0, 1));
                a8 = 8'($urandom); b8 = 8'($urandom);
            end
            @(negedge clk);
            n++;
        end
        start8 = 1'b0;
        check({tag, "_done_seen"}, 32'(done8), 32'd1);
        check({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
        check({tag, "_held_in_run"}, 32'(held), 32'd1);
        check({tag, "_sum"}, 32'(sum8), 32'(es));
        check({tag, "_cout"}, 32'(cout8), 32'(eco));
        check({tag, "_ovf"}, 32'(ovf8), 32'(eov));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done8), 32'd0);
    endtask

    task automatic run4(input int x, input int y, input int c);
        int es, eco, eov, n;
        model(4, x, y, c, es, eco, eov);
        @(negedge clk);
        a4 = 4'(x); b4 = 4'(y); cin4 = 1'(c); start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        while (done4 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("sweep4_%0h_%0h_%0d", x, y, c), {26'd0, ovf4, cout4, sum4},
              32'((eov << 5) | (eco << 4) | es));
    endtask

    initial begin
        int n, gap;
        bit seen;

        #1;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_result", {23'd0, ovf8, cout8, sum8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run8("ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
        run8("7f_01", 8'h7F, 8'h01, 1'b0, 1'b0);
        run8("80_80", 8'h80, 8'h80, 1'b0, 1'b0);
        run8("3c_a5", 8'h3C, 8'hA5, 1'b1, 1'b0);

        // start held high: second operands are taken in DONE with no IDLE bubble
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20;
        n = 0;
        while (done8 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_sum", 32'(sum8), 32'h03);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (done8 !== 1'b1 && gap < 40);
        start8 = 1'b0;
        check("b2b_gap", 32'(gap), 32'd9);
        check("b2b_second_sum", 32'(sum8), 32'h30);

        // Asynchronous reset mid-RUN
        run8("pre_rst", 8'h3C, 8'hA5, 1'b1, 1'b0);
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h66; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy8), 32'd0);
        check("arst_done", 32'(done8), 32'd0);
        check("arst_sum", 32'(sum8), 32'd0);
        check("arst_cout_ovf", {30'd0, cout8, ovf8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run8("after_rst", 8'h05, 8'h06, 1'b0, 1'b0);

        // clr mid-RUN: no done, previous result retained
        run8("pre_clr", 8'h11, 8'h22, 1'b0, 1'b0);
        @(negedge clk);
        a8 = 8'h40; b8 = 8'h40; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0;
        check("clr_busy", 32'(busy8), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done8 === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        check("clr_no_done", 32'(seen), 32'd0);
        check("clr_sum_kept", 32'(sum8), 32'h33);

        // clr and start together: clr wins
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1; clr8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; clr8 = 1'b0;
        check("clr_beats_start", 32'(busy8), 32'd0);

        for (int i = 0; i < 60; i++)
            run8("rand", 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);

        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++)
                    run4(x, y, c);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
